// File: rtl/bus_txn_pkg.sv
// Shared types and constants for the bus transaction initiator.
// Holds the FSM state encoding, the read/write direction constants, the
// default data width, and the command record held in the command queue.
package bus_txn_pkg;

   localparam int   DEFAULT_DATA_W = 8;
   localparam logic RW_WRITE       = 1'b0;
   localparam logic RW_READ        = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_ACK,
      WAIT_DONE,
      RESP
   } state_t;

   // Command record at the default width; the top re-declares it at its own
   // DATA_W so a non-default width stays consistent.
   typedef struct packed {
      logic                      rw;
      logic [DEFAULT_DATA_W-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/bus_txn_cmd_fifo.sv
// Synchronous command queue for the bus transaction initiator.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write an entry (ignored while full)
//   pop, rdata      rdata is the head entry; pop removes it (ignored while empty)
//   full, empty     occupancy flags
//   count           number of entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module bus_txn_cmd_fifo
   import bus_txn_pkg::*;
#(
   parameter int WIDTH = DEFAULT_DATA_W + 1,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/bus_txn_initiator.sv
// Initiator end of the req/rw/ack/busy/done/data_valid bus protocol.
// Queues read/write commands, issues one bus transaction at a time and
// returns one response per command, in order.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cmd_valid/ready/rw/wdata            command push interface
//   rsp_valid/ready/rw/rdata/err        response interface (held until taken)
//   bus_req/rw/wdata                    request side to the responder
//   bus_ack/busy/done/data_valid/rdata  responder side
//   idle, fifo_count                    status
// Optional feature macro: BUS_TXN_INITIATOR_TIMEOUT_EN adds a per-transaction
// watchdog of TIMEOUT_CYCLES cycles in WAIT_ACK/WAIT_DONE.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a queued command and bus_busy low
// REQ       | one-cycle bus_req pulse, head command on bus_rw/bus_wdata
// WAIT_ACK  | waiting for bus_ack (bus_done alone is a protocol error)
// WAIT_DONE | capturing read data, waiting for bus_done
// RESP      | response presented until rsp_ready, then head is popped
module bus_txn_initiator
   import bus_txn_pkg::*;
#(
   parameter int DATA_W         = DEFAULT_DATA_W,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_rw,
   input  logic [DATA_W-1:0]            cmd_wdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic                         rsp_rw,
   output logic [DATA_W-1:0]            rsp_rdata,
   output logic                         rsp_err,
   output logic                         bus_req,
   output logic                         bus_rw,
   output logic [DATA_W-1:0]            bus_wdata,
   input  logic                         bus_ack,
   input  logic                         bus_busy,
   input  logic                         bus_done,
   input  logic                         bus_data_valid,
   input  logic [DATA_W-1:0]            bus_rdata,
   output logic                         idle,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

   typedef struct packed {
      logic              rw;
      logic [DATA_W-1:0] wdata;
   } cmd_w_t;

   cmd_w_t            cmd_in;
   cmd_w_t            head;
   state_t            state;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              start;
   logic              waiting;
   logic              tmo;
   logic              rd_seen;
   logic [DATA_W-1:0] rd_data;
   logic              finish;
   logic              fin_err;
   logic [DATA_W-1:0] fin_rdata;

   assign cmd_in    = {cmd_rw, cmd_wdata};
   assign cmd_ready = !fifo_full;
   assign pop       = (state == RESP) && rsp_ready;
   assign start     = (state == IDLE) && !fifo_empty && !bus_busy;
   assign waiting   = (state == WAIT_ACK) || (state == WAIT_DONE);
   assign idle      = (state == IDLE) && fifo_empty;

   bus_txn_cmd_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .wdata (cmd_in),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef BUS_TXN_INITIATOR_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] tmo_cnt;

   // Down-counter loaded on REQ entry; terminal count lands exactly
   // TIMEOUT_CYCLES cycles after WAIT_ACK entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (start) begin
         tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
      end else if (waiting && (tmo_cnt != '0)) begin
         tmo_cnt <= tmo_cnt - 1'b1;
      end
   end

   assign tmo = waiting && (tmo_cnt == '0);
`else
   assign tmo = 1'b0;
`endif

   // A bus_done in the expiry cycle counts as normal completion.
   always_comb begin
      finish    = 1'b0;
      fin_err   = 1'b0;
      fin_rdata = '0;
      if (waiting && (bus_done || tmo)) begin
         finish = 1'b1;
         if (!bus_done)
            fin_err = 1'b1;
         else if ((state == WAIT_ACK) && !bus_ack)
            fin_err = 1'b1;
         else if ((bus_rw == RW_READ) && !(rd_seen || bus_data_valid))
            fin_err = 1'b1;
         if ((bus_rw == RW_READ) && !fin_err)
            fin_rdata = bus_data_valid ? bus_rdata : rd_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bus_req   <= 1'b0;
         bus_rw    <= RW_WRITE;
         bus_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rw    <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         rd_seen   <= 1'b0;
         rd_data   <= '0;
      end else begin
         bus_req <= 1'b0;
         if (waiting && bus_data_valid) begin
            rd_seen <= 1'b1;
            rd_data <= bus_rdata;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= REQ;
                  bus_req   <= 1'b1;
                  bus_rw    <= head.rw;
                  bus_wdata <= head.wdata;
                  rd_seen   <= 1'b0;
               end
            end
            REQ: state <= WAIT_ACK;
            WAIT_ACK, WAIT_DONE: begin
               if (finish) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rw    <= bus_rw;
                  rsp_rdata <= fin_rdata;
                  rsp_err   <= fin_err;
               end else if ((state == WAIT_ACK) && bus_ack) begin
                  state <= WAIT_DONE;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_txn_initiator.sv
// Directed bench for bus_txn_initiator: a scripted responder drives the bus
// side; expected values are hand-derived per scenario.
module tb_bus_txn_initiator;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_rw;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_rw;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       bus_req;
   logic       bus_rw;
   logic [7:0] bus_wdata;
   logic       bus_ack;
   logic       bus_busy;
   logic       bus_done;
   logic       bus_data_valid;
   logic [7:0] bus_rdata;
   logic       idle;
   logic [2:0] fifo_count;

   int errors = 0;
   int checks = 0;
   int req_count = 0;

   bus_txn_initiator #(
      .DATA_W         (8),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_rw         (cmd_rw),
      .cmd_wdata      (cmd_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_rw         (rsp_rw),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .bus_req        (bus_req),
      .bus_rw         (bus_rw),
      .bus_wdata      (bus_wdata),
      .bus_ack        (bus_ack),
      .bus_busy       (bus_busy),
      .bus_done       (bus_done),
      .bus_data_valid (bus_data_valid),
      .bus_rdata      (bus_rdata),
      .idle           (idle),
      .fifo_count     (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (rst_n && bus_req) req_count <= req_count + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic rw, input logic [7:0] wd);
      cmd_valid = 1'b1; cmd_rw = rw; cmd_wdata = wd;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_req(output int cyc);
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         cyc++;
         if (bus_req) break;
      end
   endtask

   // Called in the cycle where ack should be raised minus ack_dly; returns in
   // the cycle after done, where the response is expected to be visible.
   task automatic respond(input int ack_dly, input int done_dly, input logic dv, input logic [7:0] rd);
      for (int i = 0; i < ack_dly; i++) step();
      bus_ack = 1'b1;
      if (done_dly == 0) begin
         bus_done = 1'b1; bus_data_valid = dv; bus_rdata = rd;
      end
      step();
      bus_ack = 1'b0; bus_done = 1'b0; bus_data_valid = 1'b0;
      if (done_dly > 0) begin
         for (int i = 1; i < done_dly; i++) step();
         bus_done = 1'b1; bus_data_valid = dv; bus_rdata = rd;
         step();
         bus_done = 1'b0; bus_data_valid = 1'b0;
      end
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if ({cmd_ready, idle, bus_req, rsp_valid} !== 4'b1100) begin errors++; $display("FAIL reset_flags: got %b expected 1100", {cmd_ready, idle, bus_req, rsp_valid}); end
      checks++; if ({bus_rw, bus_wdata, rsp_rw, rsp_rdata, rsp_err} !== 19'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {bus_rw, bus_wdata, rsp_rw, rsp_rdata, rsp_err}); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_write();
      int cyc;
      push(1'b0, 8'hA5);
      checks++; if (fifo_count !== 3'd1 || idle !== 1'b0) begin errors++; $display("FAIL wr_queued: got count=%0d idle=%b expected 1 0", fifo_count, idle); end
      wait_req(cyc);
      checks++; if (cyc !== 1 || bus_rw !== 1'b0 || bus_wdata !== 8'hA5) begin errors++; $display("FAIL wr_req: got cyc=%0d rw=%b wd=%h expected 1 0 a5", cyc, bus_rw, bus_wdata); end
      step();
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL wr_req_pulse: got %b expected 0", bus_req); end
      bus_ack = 1'b1; step(); bus_ack = 1'b0;
      step(); step();
      bus_done = 1'b1;
      checks++; if (bus_wdata !== 8'hA5 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_hold: got wd=%h rv=%b expected a5 0", bus_wdata, rsp_valid); end
      step(); bus_done = 1'b0;
      checks++; if ({rsp_valid, rsp_rw, rsp_err, rsp_rdata} !== {3'b100, 8'h00} || bus_wdata !== 8'hA5) begin errors++; $display("FAIL wr_rsp: got v/rw/err/rd=%b%b%b %h wd=%h expected 100 00 a5", rsp_valid, rsp_rw, rsp_err, rsp_rdata, bus_wdata); end
      step();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_held: got %b expected 1", rsp_valid); end
      take_rsp();
      checks++; if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || idle !== 1'b1) begin errors++; $display("FAIL wr_pop: got rv=%b cnt=%0d idle=%b expected 0 0 1", rsp_valid, fifo_count, idle); end
   endtask

   task automatic test_read();
      int cyc;
      push(1'b1, 8'h00);
      wait_req(cyc);
      checks++; if (cyc !== 1 || bus_rw !== 1'b1) begin errors++; $display("FAIL rd_req: got cyc=%0d rw=%b expected 1 1", cyc, bus_rw); end
      respond(1, 2, 1'b1, 8'h3C);
      checks++; if ({rsp_valid, rsp_rw, rsp_err, rsp_rdata} !== {3'b110, 8'h3C}) begin errors++; $display("FAIL rd_rsp: got %b%b%b %h expected 110 3c", rsp_valid, rsp_rw, rsp_err, rsp_rdata); end
      take_rsp();
      // ack and done in the same cycle, data captured earlier then overwritten
      push(1'b1, 8'h00);
      wait_req(cyc);
      respond(1, 0, 1'b1, 8'h5A);
      checks++; if ({rsp_valid, rsp_rw, rsp_err, rsp_rdata} !== {3'b110, 8'h5A}) begin errors++; $display("FAIL rd_ackdone: got %b%b%b %h expected 110 5a", rsp_valid, rsp_rw, rsp_err, rsp_rdata); end
      take_rsp();
   endtask

   task automatic test_back_to_back();
      int cyc;
      req_count = 0;
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_wdata = 8'h11; step();
      cmd_rw = 1'b1; cmd_wdata = 8'h00; step();
      checks++; if (bus_req !== 1'b1 || bus_rw !== 1'b0 || bus_wdata !== 8'h11) begin errors++; $display("FAIL b2b_req1: got req=%b rw=%b wd=%h expected 1 0 11", bus_req, bus_rw, bus_wdata); end
      cmd_rw = 1'b0; cmd_wdata = 8'h22; step();
      cmd_valid = 1'b0;
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", fifo_count); end
      respond(0, 2, 1'b0, 8'h00);
      checks++; if ({rsp_valid, rsp_rw, rsp_err} !== 3'b100) begin errors++; $display("FAIL b2b_rsp1: got %b expected 100", {rsp_valid, rsp_rw, rsp_err}); end
      wait_req(cyc);
      checks++; if (cyc !== 2 || bus_rw !== 1'b1 || fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_req2: got cyc=%0d rw=%b cnt=%0d expected 2 1 2", cyc, bus_rw, fifo_count); end
      respond(1, 1, 1'b1, 8'h77);
      checks++; if ({rsp_valid, rsp_rw, rsp_err, rsp_rdata} !== {3'b110, 8'h77}) begin errors++; $display("FAIL b2b_rsp2: got %b%b%b %h expected 110 77", rsp_valid, rsp_rw, rsp_err, rsp_rdata); end
      wait_req(cyc);
      checks++; if (cyc !== 2 || bus_rw !== 1'b0 || bus_wdata !== 8'h22) begin errors++; $display("FAIL b2b_req3: got cyc=%0d rw=%b wd=%h expected 2 0 22", cyc, bus_rw, bus_wdata); end
      respond(1, 1, 1'b0, 8'h00);
      checks++; if ({rsp_valid, rsp_rw, rsp_err, rsp_rdata} !== {3'b100, 8'h00}) begin errors++; $display("FAIL b2b_rsp3: got %b%b%b %h expected 100 00", rsp_valid, rsp_rw, rsp_err, rsp_rdata); end
      step();
      rsp_ready = 1'b0;
      checks++; if (fifo_count !== 3'd0 || idle !== 1'b1 || req_count !== 3) begin errors++; $display("FAIL b2b_end: got cnt=%0d idle=%b reqs=%0d expected 0 1 3", fifo_count, idle, req_count); end
   endtask

   task automatic test_full();
      int cyc;
      logic [3:0] rdy_hist;
      req_count = 0;
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_rw = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cmd_wdata = 8'(i + 1);
         step();
         if (i < 4) rdy_hist[i] = cmd_ready;
      end
      cmd_valid = 1'b0;
      checks++; if (rdy_hist !== 4'b0111) begin errors++; $display("FAIL full_ready: got %b expected 0111", rdy_hist); end
      checks++; if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin errors++; $display("FAIL full_count: got cnt=%0d rdy=%b expected 4 0", fifo_count, cmd_ready); end
      respond(0, 1, 1'b0, 8'h00);
      step(); step(); step();
      checks++; if (rsp_valid !== 1'b1 || req_count !== 1 || bus_wdata !== 8'h01) begin errors++; $display("FAIL full_stall: got rv=%b reqs=%0d wd=%h expected 1 1 01", rsp_valid, req_count, bus_wdata); end
      take_rsp();
      checks++; if (fifo_count !== 3'd3 || cmd_ready !== 1'b1) begin errors++; $display("FAIL full_pop: got cnt=%0d rdy=%b expected 3 1", fifo_count, cmd_ready); end
      for (int i = 2; i <= 4; i++) begin
         wait_req(cyc);
         checks++; if (cyc !== 1 || bus_wdata !== 8'(i)) begin errors++; $display("FAIL full_drain%0d: got cyc=%0d wd=%h expected 1 %h", i, cyc, bus_wdata, 8'(i)); end
         respond(1, 1, 1'b0, 8'h00);
         take_rsp();
      end
      checks++; if (fifo_count !== 3'd0 || idle !== 1'b1) begin errors++; $display("FAIL full_end: got cnt=%0d idle=%b expected 0 1", fifo_count, idle); end
   endtask

   task automatic test_errors();
      int cyc;
      push(1'b1, 8'h00);
      wait_req(cyc);
      respond(1, 2, 1'b0, 8'hEE);
      checks++; if ({rsp_valid, rsp_rw, rsp_err, rsp_rdata} !== {3'b111, 8'h00}) begin errors++; $display("FAIL err_nodata: got %b%b%b %h expected 111 00", rsp_valid, rsp_rw, rsp_err, rsp_rdata); end
      take_rsp();
      push(1'b0, 8'h44);
      wait_req(cyc);
      step();
      bus_done = 1'b1; step(); bus_done = 1'b0;
      checks++; if ({rsp_valid, rsp_rw, rsp_err, rsp_rdata} !== {3'b101, 8'h00}) begin errors++; $display("FAIL err_noack: got %b%b%b %h expected 101 00", rsp_valid, rsp_rw, rsp_err, rsp_rdata); end
      take_rsp();
      req_count = 0;
      bus_busy = 1'b1;
      push(1'b0, 8'h55);
      for (int i = 0; i < 5; i++) step();
      checks++; if (req_count !== 0 || bus_req !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL busy_hold: got reqs=%0d req=%b idle=%b expected 0 0 0", req_count, bus_req, idle); end
      bus_busy = 1'b0;
      wait_req(cyc);
      checks++; if (cyc !== 1 || bus_wdata !== 8'h55) begin errors++; $display("FAIL busy_release: got cyc=%0d wd=%h expected 1 55", cyc, bus_wdata); end
      respond(1, 1, 1'b0, 8'h00);
      take_rsp();
   endtask

   task automatic test_reset_mid();
      int cyc;
      push(1'b1, 8'h00);
      wait_req(cyc);
      step();
      bus_ack = 1'b1; step(); bus_ack = 1'b0;
      bus_data_valid = 1'b1; bus_rdata = 8'h99; step(); bus_data_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({cmd_ready, idle, bus_req, rsp_valid, bus_rw, bus_wdata, rsp_rdata, rsp_err, fifo_count} !== {4'b1100, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0}) begin errors++; $display("FAIL rst_mid: got %h expected %h", {cmd_ready, idle, bus_req, rsp_valid, bus_rw, bus_wdata, rsp_rdata, rsp_err, fifo_count}, {4'b1100, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0}); end
      @(negedge clk); rst_n = 1'b1;
      req_count = 0;
      bus_done = 1'b1; step(); bus_done = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checks++; if (rsp_valid !== 1'b0 || req_count !== 0 || idle !== 1'b1) begin errors++; $display("FAIL rst_norsp: got rv=%b reqs=%0d idle=%b expected 0 0 1", rsp_valid, req_count, idle); end
   endtask

`ifdef BUS_TXN_INITIATOR_TIMEOUT_EN
   task automatic test_timeout();
      int cyc;
      push(1'b1, 8'h00);
      wait_req(cyc);
      step();
      for (int i = 0; i < 15; i++) step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b expected 0", rsp_valid); end
      step();
      checks++; if ({rsp_valid, rsp_rw, rsp_err, rsp_rdata} !== {3'b111, 8'h00}) begin errors++; $display("FAIL tmo_fire: got %b%b%b %h expected 111 00", rsp_valid, rsp_rw, rsp_err, rsp_rdata); end
      take_rsp();
      push(1'b0, 8'h66);
      wait_req(cyc);
      step();
      bus_ack = 1'b1; step(); bus_ack = 1'b0;
      for (int i = 0; i < 14; i++) step();
      bus_done = 1'b1; step(); bus_done = 1'b0;
      checks++; if ({rsp_valid, rsp_rw, rsp_err} !== 3'b100) begin errors++; $display("FAIL tmo_done_prio: got %b expected 100", {rsp_valid, rsp_rw, rsp_err}); end
      take_rsp();
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_wdata = 8'h00;
      rsp_ready = 1'b0;
      bus_ack = 1'b0; bus_busy = 1'b0; bus_done = 1'b0;
      bus_data_valid = 1'b0; bus_rdata = 8'h00;
      #12;
      test_reset();
      @(negedge clk); rst_n = 1'b1;
      step();
      test_write();
      test_read();
      test_back_to_back();
      test_full();
      test_errors();
`ifdef BUS_TXN_INITIATOR_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_txn_initiator.md
Name: bus_txn_initiator

Overview:
- Initiator (requester) end of the req/rw/ack/busy/done/data_valid bus transaction protocol; drives a responder such as the bus transaction TT-UM block.
- Accepts queued read/write commands from local logic and issues one bus transaction at a time.
- Collects write completion or read data and returns one response per command, in order.

Parameters:
- DATA_W, 8, width of write data and read data.
- FIFO_DEPTH, 4, command queue entries; power of two, ≥2.
- TIMEOUT_CYCLES, 16, watchdog limit per transaction (used only with the optional feature).

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue not full; push when cmd_valid&&cmd_ready
- cmd_rw  in  1  0=WRITE, 1=READ
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rw  out  1  rw of completed command
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  protocol error or timeout
- bus_req  out  1  one-cycle request pulse
- bus_rw  out  1  transaction direction
- bus_wdata  out  DATA_W  write data, stable from REQ until DONE
- bus_ack  in  1  responder accepted request
- bus_busy  in  1  responder busy
- bus_done  in  1  transaction complete
- bus_data_valid  in  1  bus_rdata valid (reads)
- bus_rdata  in  DATA_W  read data
- idle  out  1  FSM in IDLE and queue empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queue occupancy

Behaviour:
- Reset (async, rst_n=0): state=IDLE, queue empty, fifo_count=0, cmd_ready=1, bus_req=0, bus_rw=0, bus_wdata=0, rsp_valid=0, rsp_rw=0, rsp_rdata=0, rsp_err=0, idle=1. Reset mid-transaction abandons it; no response is produced.
- Queue: push on cmd_valid&&cmd_ready. cmd_ready=0 when full. Head is popped only when its response is consumed. Push while full is ignored. Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, REQ, WAIT_ACK, WAIT_DONE, RESP.
- IDLE: if the queue is non-empty and bus_busy=0, go to REQ. bus_busy=1 holds IDLE.
- REQ: bus_req=1 for exactly one cycle. bus_rw and bus_wdata come from the queue head. Go to WAIT_ACK.
- Earliest bus_req is one cycle after the push edge.
- WAIT_ACK: on bus_ack go to WAIT_DONE. If bus_ack and bus_done arrive in the same cycle, go straight to RESP.
- WAIT_DONE: for reads, capture bus_rdata on any cycle with bus_data_valid=1; the last capture wins. On bus_done go to RESP.
- Error cases, each sets rsp_err=1 and rsp_rdata=0:
  - read completes with no data_valid seen since REQ;
  - bus_done seen in WAIT_ACK without bus_ack.
- RESP: rsp_valid=1 with rsp_rw, rsp_rdata and rsp_err held stable until rsp_ready. On rsp_valid&&rsp_ready: pop the head, clear rsp_valid, go to IDLE. Back-to-back commands need at least one IDLE cycle.
- bus_wdata and bus_rw hold their values outside REQ..WAIT_DONE; bus_req=0 in all states except REQ.
- idle=1 only when state=IDLE and fifo_count=0.

Optional Feature:
- Macro: BUS_TXN_INITIATOR_TIMEOUT_EN.
- Defined: a cycle counter clears on entry to REQ and counts in WAIT_ACK and WAIT_DONE. When it reaches TIMEOUT_CYCLES, go to RESP with rsp_err=1 and rsp_rdata=0. A bus_done arriving in the same cycle as expiry takes priority (normal completion).
- Not defined: no counter; the FSM waits indefinitely for bus_ack and bus_done.

Decomposition:
- Package bus_txn_pkg holds:
  - state enum (IDLE, REQ, WAIT_ACK, WAIT_DONE, RESP);
  - RW_WRITE=0 and RW_READ=1 constants;
  - default DATA_W;
  - command struct {rw, wdata}.
- Sub-module bus_txn_cmd_fifo: synchronous FIFO with FIFO_DEPTH entries, push/pop/full/empty/count, async active-low reset.

Test Plan:
- WRITE: push rw=0, wdata=0xA5; responder acks 1 cycle after req and gives done 3 cycles later -> one bus_req pulse with bus_rw=0 and bus_wdata=0xA5 held through done; rsp_valid with rsp_rw=0, rsp_err=0, rsp_rdata=0x00.
- READ: push rw=1; responder asserts data_valid with rdata=0x3C together with done -> rsp_rw=1, rsp_rdata=0x3C, rsp_err=0.
- Back-to-back: push WRITE 0x11, READ, WRITE 0x22 in consecutive cycles with rsp_ready=1 -> fifo_count reaches 3; exactly three bus_req pulses in order, each after the previous response; responses return in order.
- Backpressure and full: hold rsp_ready=0 and push 5 commands -> cmd_ready drops after 4; 5th push ignored; only one bus_req issued until the response is taken.
- Errors: read with done but no data_valid -> rsp_err=1, rdata=0. bus_busy=1 at push -> no bus_req until busy drops.
- Timeout and reset (with BUS_TXN_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES=16): no ack -> rsp_err=1 exactly 16 cycles after WAIT_ACK entry. rst_n low during WAIT_DONE -> all outputs return to reset values immediately and no response is produced.
